axi_llc_sram_rsp_buf: RTL

//  Request/response front-end for one LLC SRAM macro wrapper (tag or data array).

---
 rtl/axi_llc_sram_rsp_buf.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axi_llc_sram_rsp_buf.sv
// SRAM request/response front-end: forwards LLC requests to one SRAM macro, tracks reads across
// the fixed read latency and buffers returned data in a credit-protected in-order response FIFO.
module axi_llc_sram_rsp_buf #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned Depth     = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic                 sram_gnt_i,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth:0]   CreditMax = (CntWidth + 1)'(Depth);
    localparam logic [CntWidth-1:0] CntFull   = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] PtrLast   = PtrWidth'(Depth - 1);

    logic                 credit_ok;
    logic                 rd_accept;
    logic                 push;
    logic                 pop;

    logic [Latency-1:0]   pipe_vld_q, pipe_vld_d;
    logic [IdWidth-1:0]   pipe_id_q [Latency];
    logic [IdWidth-1:0]   pipe_id_d [Latency];

    logic [CntWidth-1:0]  inflight_cnt_q, inflight_cnt_d;
    logic [CntWidth-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;

    logic [DataWidth-1:0] fifo_data_mem [Depth];
    logic [IdWidth-1:0]   fifo_id_mem [Depth];

    logic [DataWidth-1:0] head_data, hold_data_q, hold_data_d;
    logic [IdWidth-1:0]   head_id, hold_id_q, hold_id_d;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both in-flight reads and buffered responses, using registered counts only,
    // so a same-cycle pop never feeds back into req_ready_o.
    assign credit_ok   = ({1'b0, fifo_cnt_q} + {1'b0, inflight_cnt_q}) < CreditMax;
    assign req_ready_o = sram_gnt_i & (req_we_i | credit_ok);
    assign rd_accept   = req_valid_i & req_ready_o & ~req_we_i;

    assign sram_req_o   = req_valid_i & req_ready_o;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign push        = pipe_vld_q[Latency-1];
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;

    assign head_data  = fifo_data_mem[rd_ptr_q];
    assign head_id    = fifo_id_mem[rd_ptr_q];
    assign rsp_data_o = rsp_valid_o ? head_data : hold_data_q;
    assign rsp_id_o   = rsp_valid_o ? head_id : hold_id_q;
    assign busy_o     = (inflight_cnt_q != '0) | (fifo_cnt_q != '0);

    always_comb begin
        pipe_vld_d = pipe_vld_q;
        pipe_id_d  = pipe_id_q;
        for (int i = Latency - 1; i > 0; i--) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
        pipe_vld_d[0] = rd_accept;
        pipe_id_d[0]  = req_id_i;
    end

    always_comb begin
        inflight_cnt_d = inflight_cnt_q;
        fifo_cnt_d     = fifo_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        hold_data_d    = hold_data_q;
        hold_id_d      = hold_id_q;

        if (rd_accept && !push) begin
            inflight_cnt_d = inflight_cnt_q + 1'b1;
        end else if (!rd_accept && push) begin
            inflight_cnt_d = inflight_cnt_q - 1'b1;
        end

        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        // The popped head is remembered so the outputs keep showing it while the FIFO is empty.
        if (pop) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            hold_data_d = head_data;
            hold_id_d   = head_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_id_q[i] <= '0;
            end
            inflight_cnt_q <= '0;
            fifo_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            hold_data_q    <= '0;
            hold_id_q      <= '0;
        end else begin
            pipe_vld_q     <= pipe_vld_d;
            pipe_id_q      <= pipe_id_d;
            inflight_cnt_q <= inflight_cnt_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            hold_data_q    <= hold_data_d;
            hold_id_q      <= hold_id_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_data_mem[wr_ptr_q] <= sram_rdata_i;
            fifo_id_mem[wr_ptr_q]   <= pipe_id_q[Latency-1];
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && (fifo_cnt_q == CntFull)));
        end
    end
`endif

endmodule
